// File: rtl/pattern_pkg.sv
// Shared mode encodings and helpers for the LED pattern shifter.
package pattern_pkg;

  localparam int unsigned MODE_W = 2;

  typedef logic [MODE_W-1:0] mode_t;

  localparam mode_t MODE_RING    = 2'd0;
  localparam mode_t MODE_BOUNCE  = 2'd1;
  localparam mode_t MODE_JOHNSON = 2'd2;
  localparam mode_t MODE_BAR     = 2'd3;

  // Bounce travel direction.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // LSB of the start pattern for a mode; every other bit of a start pattern is zero.
  function automatic logic start_lsb(input mode_t m);
    return (m == MODE_RING) || (m == MODE_BOUNCE);
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Step prescaler: one tick every prescale+1 enabled cycles.
module tick_gen #(
  parameter int unsigned PW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          clear,
  input  logic [PW-1:0] prescale,
  output logic          tick_c
);

  logic [PW-1:0] pre_cnt;

  // Tick once the count reaches the (possibly lowered) prescale value.
  always_comb begin
    tick_c = en && !clear && (pre_cnt >= prescale);
  end

  // Prescale counter: cleared on restart, frozen while disabled.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_cnt <= '0;
    end else if (clear) begin
      pre_cnt <= '0;
    end else if (en) begin
      pre_cnt <= tick_c ? '0 : pre_cnt + PW'(1);
    end
  end

endmodule

// File: rtl/pattern_shifter.sv
// Parametrised LED pattern generator: ring, bounce, Johnson and bar modes.
module pattern_shifter
  import pattern_pkg::*;
#(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned PW    = 16,
  localparam int unsigned POS_W = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  mode_t            mode,
  input  logic             dir_in,
  input  logic [PW-1:0]    prescale,
  output logic [WIDTH-1:0] pattern,
  output logic [POS_W-1:0] pos,
  output logic             step,
  output logic             wrap
);

  localparam logic [POS_W-1:0] POS_MSB      = POS_W'(WIDTH - 1);
  localparam logic [POS_W-1:0] POS_BAR_END  = POS_W'(WIDTH);
  localparam logic [POS_W-1:0] POS_JOHN_END = POS_W'(2 * WIDTH - 1);

  mode_t            mode_q;
  dir_e             dir_q;
  dir_e             dir_n;
  logic             restart_c;
  logic             tick_c;
  logic [WIDTH-1:0] pattern_n;
  logic [POS_W-1:0] pos_n;
  logic             wrap_n;

  // A mode change seen on the input forces a restart on the next edge.
  always_comb begin
    restart_c = (mode != mode_q);
  end

  tick_gen #(
    .PW (PW)
  ) u_tick_gen (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .clear    (restart_c),
    .prescale (prescale),
    .tick_c   (tick_c)
  );

  // Mode register samples the input every cycle, independent of en.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q <= MODE_RING;
    end else begin
      mode_q <= mode;
    end
  end

  // Per-mode next state, applied only on a tick.
  always_comb begin
    pattern_n = pattern;
    pos_n     = pos;
    dir_n     = dir_q;
    wrap_n    = 1'b0;
    unique case (mode_q)
      MODE_RING: begin
        if (dir_in) begin
          pos_n = (pos == '0) ? POS_MSB : pos - POS_W'(1);
        end else begin
          pos_n = (pos == POS_MSB) ? '0 : pos + POS_W'(1);
        end
        pattern_n = WIDTH'(1) << pos_n;
      end
      MODE_BOUNCE: begin
        // Reverse at either end so each end bit is shown exactly once per pass.
        if (dir_q == DIR_UP) begin
          if (pos == POS_MSB) begin
            pos_n = pos - POS_W'(1);
            dir_n = DIR_DOWN;
          end else begin
            pos_n = pos + POS_W'(1);
          end
        end else begin
          if (pos == '0) begin
            pos_n = pos + POS_W'(1);
            dir_n = DIR_UP;
          end else begin
            pos_n = pos - POS_W'(1);
          end
        end
        pattern_n = WIDTH'(1) << pos_n;
      end
      MODE_JOHNSON: begin
        pos_n     = (pos == POS_JOHN_END) ? '0 : pos + POS_W'(1);
        pattern_n = {pattern[WIDTH-2:0], ~pattern[WIDTH-1]};
      end
      MODE_BAR: begin
        pos_n     = (pos == POS_BAR_END) ? '0 : pos + POS_W'(1);
        pattern_n = (pos_n == '0) ? '0 : {pattern[WIDTH-2:0], 1'b1};
      end
    endcase
    // Position 0 is the start state in every mode; bounce only reaches it moving down.
    wrap_n = (pos_n == '0);
  end

  // Output and sequence state registers; restart wins over a coincident tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pattern <= WIDTH'(1);
      pos     <= '0;
      dir_q   <= DIR_UP;
      step    <= 1'b0;
      wrap    <= 1'b0;
    end else if (restart_c) begin
      pattern <= WIDTH'(start_lsb(mode));
      pos     <= '0;
      dir_q   <= DIR_UP;
      step    <= 1'b0;
      wrap    <= 1'b0;
    end else if (tick_c) begin
      pattern <= pattern_n;
      pos     <= pos_n;
      dir_q   <= dir_n;
      step    <= 1'b1;
      wrap    <= wrap_n;
    end else begin
      step    <= 1'b0;
      wrap    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pattern_shifter.sv
// Directed bench for pattern_shifter with a scoreboard fed by a sequence-index model.
module tb_pattern_shifter;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned PW    = 16;
  localparam int unsigned POS_W = $clog2(2 * WIDTH);

  logic             clk = 1'b0;
  logic             reset;
  logic             en;
  logic [1:0]       mode;
  logic             dir_in;
  logic [PW-1:0]    prescale;
  logic [WIDTH-1:0] pattern;
  logic [POS_W-1:0] pos;
  logic             step;
  logic             wrap;

  typedef struct {
    logic [WIDTH-1:0] pat;
    logic [POS_W-1:0] pos;
    logic             step;
    logic             wrap;
  } exp_t;

  exp_t sb[$];

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Model: sequence index within the current mode's period, prescale count, sampled mode.
  logic [1:0] m_modeq;
  int         m_idx;
  int         m_cnt;

  pattern_shifter #(
    .WIDTH (WIDTH),
    .PW    (PW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .mode     (mode),
    .dir_in   (dir_in),
    .prescale (prescale),
    .pattern  (pattern),
    .pos      (pos),
    .step     (step),
    .wrap     (wrap)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int period(input logic [1:0] m);
    case (m)
      2'd0:    return WIDTH;
      2'd1:    return 2 * WIDTH - 2;
      2'd2:    return 2 * WIDTH;
      default: return WIDTH + 1;
    endcase
  endfunction

  function automatic logic [POS_W-1:0] exp_pos(input logic [1:0] m, input int i);
    if (m == 2'd1 && i >= WIDTH) return POS_W'(2 * WIDTH - 2 - i);
    return POS_W'(i);
  endfunction

  function automatic logic [WIDTH-1:0] exp_pat(input logic [1:0] m, input int i);
    logic [WIDTH-1:0] ones;
    logic [63:0]      one64;
    ones  = '1;
    one64 = 64'd1;
    case (m)
      2'd0:    return WIDTH'(1) << i;
      2'd1:    return WIDTH'(1) << exp_pos(m, i);
      2'd2:    return (i <= WIDTH) ? WIDTH'((one64 << i) - 64'd1) : ones << (i - WIDTH);
      default: return WIDTH'((one64 << i) - 64'd1);
    endcase
  endfunction

  task automatic model_reset();
    m_modeq = 2'd0;
    m_idx   = 0;
    m_cnt   = 0;
  endtask

  // Predict the state after the coming edge from the inputs now applied.
  task automatic model_edge();
    exp_t e;
    int   per;
    e.step = 1'b0;
    e.wrap = 1'b0;
    if (mode != m_modeq) begin
      m_idx = 0;
      m_cnt = 0;
    end else if (en) begin
      if (m_cnt >= int'(prescale)) begin
        m_cnt = 0;
        per   = period(mode);
        if (mode == 2'd0 && dir_in) m_idx = (m_idx + per - 1) % per;
        else                        m_idx = (m_idx + 1) % per;
        e.step = 1'b1;
        e.wrap = (m_idx == 0);
      end else begin
        m_cnt++;
      end
    end
    m_modeq = mode;
    e.pat   = exp_pat(m_modeq, m_idx);
    e.pos   = exp_pos(m_modeq, m_idx);
    sb.push_back(e);
  endtask

  // One clock: predict, run the edge, sample 1 ns later and compare against the scoreboard.
  task automatic cyc(input string tag);
    exp_t e;
    model_edge();
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, ".pattern"}, 32'(pattern), 32'(e.pat));
    check({tag, ".pos"},     32'(pos),     32'(e.pos));
    check({tag, ".step"},    32'(step),    32'(e.step));
    check({tag, ".wrap"},    32'(wrap),    32'(e.wrap));
  endtask

  int wraps;
  int n;

  initial begin
    reset    = 1'b0;
    en       = 1'b1;
    mode     = 2'd0;
    dir_in   = 1'b0;
    prescale = '0;
    model_reset();

    // Reset held low for three cycles.
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("rst.pattern", 32'(pattern), 32'h01);
      check("rst.pos",     32'(pos),     32'h0);
      check("rst.step",    32'(step),    32'h0);
      check("rst.wrap",    32'(wrap),    32'h0);
    end
    #2 reset = 1'b1;

    // Ring toward MSB, then toward LSB.
    cyc("ring_up");
    check("ring_first", 32'(pattern), 32'h02);
    for (int i = 0; i < 8; i++) cyc("ring_up");
    dir_in = 1'b1;
    for (int i = 0; i < 9; i++) cyc("ring_dn");
    dir_in = 1'b0;

    // Bounce: two full passes.
    mode = 2'd1;
    cyc("bounce_restart");
    wraps = 0;
    for (int i = 0; i < 28; i++) begin
      cyc("bounce");
      if (wrap) wraps++;
    end
    check("bounce_wraps", 32'(wraps), 32'd2);

    // Johnson: two full periods; dir_in must be ignored.
    mode   = 2'd2;
    dir_in = 1'b1;
    cyc("john_restart");
    wraps = 0;
    for (int i = 0; i < 32; i++) begin
      cyc("john");
      if (wrap) wraps++;
    end
    check("john_wraps", 32'(wraps), 32'd2);
    dir_in = 1'b0;

    // Bar: two full periods.
    mode = 2'd3;
    cyc("bar_restart");
    wraps = 0;
    for (int i = 0; i < 18; i++) begin
      cyc("bar");
      if (wrap) wraps++;
    end
    check("bar_wraps", 32'(wraps), 32'd2);

    // Prescaler with an enable gap mid-count.
    mode     = 2'd0;
    prescale = PW'(3);
    cyc("pre_restart");
    for (int i = 0; i < 10; i++) cyc("pre_run");
    en = 1'b0;
    for (int i = 0; i < 5; i++) cyc("pre_hold");
    en = 1'b1;
    for (int i = 0; i < 10; i++) cyc("pre_resume");

    // Lowering prescale below the count ticks on the next enabled cycle.
    prescale = PW'(10);
    for (int i = 0; i < 6; i++) cyc("pre_high");
    prescale = PW'(2);
    cyc("pre_lower");
    check("pre_lower_step", 32'(step), 32'h1);

    // Run ring to bit 4, then switch to Johnson.
    prescale = '0;
    n = 0;
    while (pattern !== 8'h10 && n < 16) begin
      cyc("ring_seek");
      n++;
    end
    check("ring_seek_found", 32'(pattern), 32'h10);
    mode = 2'd2;
    cyc("switch_john");
    check("switch_pattern", 32'(pattern), 32'h00);
    check("switch_pos",     32'(pos),     32'h0);
    for (int i = 0; i < 5; i++) cyc("john_run");

    // Asynchronous reset pulse between edges.
    #3 reset = 1'b0;
    #1;
    check("areset.pattern", 32'(pattern), 32'h01);
    check("areset.pos",     32'(pos),     32'h0);
    check("areset.step",    32'(step),    32'h0);
    check("areset.wrap",    32'(wrap),    32'h0);
    model_reset();
    #2 reset = 1'b1;
    cyc("post_reset_restart");
    for (int i = 0; i < 4; i++) cyc("post_reset_john");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
